// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// ---------------
// A bank of NFLAG set/reset flag bits shared by NREQ requesters. A round-robin
// arbiter accepts at most one command per cycle. Each command either sets,
// clears, toggles or leaves alone one flag. A requester can lock the bus to
// issue an uninterrupted sequence of commands. If the lock is held too long,
// it is released by force.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_valid[i]    requester i presents a command
//   req_ready[i]    requester i's command is accepted this cycle (combinational)
//   req_op          {S,R} per requester, slice i = [2i+1:2i]
//                   00 keep, 01 clear, 10 set, 11 toggle
//   req_idx         flag index per requester, slice i = [IDXW*i +: IDXW]
//   req_lock        keep the grant after this command
//   flags           registered flag bank
//   locked          bus is locked to owner
//   owner           last granted requester, or the current lock owner
//   lock_timeout    one-cycle pulse when a lock is released by force
//
// Optional interrupt (macro SR_FLAG_ARBITER_IRQ_EN):
//   irq_mask        per-flag interrupt enable
//   irq             registered OR of (flags & irq_mask)
//
// State table
//   state      | meaning
//   ST_IDLE    | round-robin arbitration among all requesters
//   ST_LOCKED  | only owner may transfer; lock timer counts down

module sr_flag_arbiter #(
    parameter int NREQ     = 4,
    parameter int NFLAG    = 8,
    parameter int IDXW     = 3,
    parameter int LOCK_MAX = 16,
    localparam int OWW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    input  logic [NREQ-1:0]        req_lock,
    output logic [NFLAG-1:0]       flags,
    output logic                   locked,
    output logic [OWW-1:0]         owner,
    output logic                   lock_timeout
`ifdef SR_FLAG_ARBITER_IRQ_EN
    ,
    input  logic [NFLAG-1:0]       irq_mask,
    output logic                   irq
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NFLAG-1:0]  flags_q, flags_d;
    logic [OWW-1:0]    owner_q, owner_d;
    logic [CNTW-1:0]   lock_cnt_q, lock_cnt_d;
    logic              lock_timeout_q, lock_timeout_d;

    logic              grant_any;
    logic [OWW-1:0]    grant_idx;
    logic [OWW-1:0]    sel_req;
    int                cand;
    logic [OWW-1:0]    cand_idx;

    logic              xfer;
    logic [1:0]        sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic              sel_lock;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = owner_q;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(owner_q) + k) % NREQ;
            cand_idx = OWW'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // While locked, the arbiter result is ignored. Only the owner is served.
    always_comb begin
        req_ready = '0;
        sel_req   = grant_idx;
        if (state_q == ST_LOCKED) begin
            sel_req            = owner_q;
            req_ready[owner_q] = req_valid[owner_q];
        end else if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        sel_op   = 2'b00;
        sel_idx  = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (OWW'(i) == sel_req) begin
                sel_op   = req_op[2*i +: 2];
                sel_idx  = req_idx[IDXW*i +: IDXW];
                sel_lock = req_lock[i];
            end
        end
    end

    // Out-of-range indices are consumed without touching the bank.
    always_comb begin
        flags_d = flags_q;
        if (xfer && (int'(sel_idx) < NFLAG)) begin
            case (sel_op)
                2'b01:   flags_d[sel_idx] = 1'b0;
                2'b10:   flags_d[sel_idx] = 1'b1;
                2'b11:   flags_d[sel_idx] = ~flags_q[sel_idx];
                default: flags_d[sel_idx] = flags_q[sel_idx];
            endcase
        end
    end

    // The lock timer holds the number of locked cycles left after the
    // current one. Zero means this is the last cycle the lock may be held.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    owner_d = grant_idx;
                    if (sel_lock) begin
                        state_d    = ST_LOCKED;
                        lock_cnt_d = CNTW'(LOCK_MAX - 1);
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_cnt_q != '0) begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
                if (xfer && !sel_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == '0) begin
                    // A command accepted in this cycle has already been
                    // applied through flags_d. Only the lock is dropped here.
                    state_d        = ST_IDLE;
                    lock_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            flags_q        <= '0;
            owner_q        <= OWW'(NREQ - 1);
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flags_q        <= flags_d;
            owner_q        <= owner_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign flags        = flags_q;
    assign locked       = (state_q == ST_LOCKED);
    assign owner        = owner_q;
    assign lock_timeout = lock_timeout_q;

`ifdef SR_FLAG_ARBITER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(flags_q & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed testbench for sr_flag_arbiter. The main instance uses 4 requesters
// and 8 flags. A second instance uses 2 requesters and 6 flags, so a 3-bit
// index can address positions beyond the bank.
module tb_sr_flag_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  req_valid, req_ready, req_lock;
    logic [7:0]  req_op;
    logic [11:0] req_idx;
    logic [7:0]  flags;
    logic        locked;
    logic [1:0]  owner;
    logic        lock_timeout;

    logic [1:0]  v6, rdy6, lk6;
    logic [3:0]  op6;
    logic [5:0]  idx6;
    logic [5:0]  flags6;
    logic        locked6;
    logic [0:0]  owner6;
    logic        to6;

`ifdef SR_FLAG_ARBITER_IRQ_EN
    logic [7:0]  irq_mask;
    logic        irq;
    logic [5:0]  irq_mask6;
    logic        irq6;
`endif

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3), .LOCK_MAX(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_idx      (req_idx),
        .req_lock     (req_lock),
        .flags        (flags),
        .locked       (locked),
        .owner        (owner),
        .lock_timeout (lock_timeout)
`ifdef SR_FLAG_ARBITER_IRQ_EN
        ,
        .irq_mask     (irq_mask),
        .irq          (irq)
`endif
    );

    sr_flag_arbiter #(.NREQ(2), .NFLAG(6), .IDXW(3), .LOCK_MAX(4)) dut6 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v6),
        .req_ready    (rdy6),
        .req_op       (op6),
        .req_idx      (idx6),
        .req_lock     (lk6),
        .flags        (flags6),
        .locked       (locked6),
        .owner        (owner6),
        .lock_timeout (to6)
`ifdef SR_FLAG_ARBITER_IRQ_EN
        ,
        .irq_mask     (irq_mask6),
        .irq          (irq6)
`endif
    );

    int ntot  = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [1:0] op,
                         input logic [2:0] idx, input logic lk);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op;
        req_idx[3*i +: 3]  = idx;
        req_lock[i]        = lk;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_idx = '0; req_lock = '0;
        v6 = '0; op6 = '0; idx6 = '0; lk6 = '0;
`ifdef SR_FLAG_ARBITER_IRQ_EN
        irq_mask = 8'h10;
        irq_mask6 = 6'h00;
`endif
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_flags", flags, 8'h00);
        chk("rst_locked", locked, 1'b0);
        chk("rst_owner", owner, 2'd3);
        chk("rst_timeout", lock_timeout, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_owner6", owner6, 1'b1);
`ifdef SR_FLAG_ARBITER_IRQ_EN
        chk("rst_irq", irq, 1'b0);
`endif

        // 1: all four requesters set their own flag; grants go 0,1,2,3
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 2'b10, 3'(i), 1'b0);
        #1;
        chk("rr_ready0", req_ready, 4'b0001);
        tick;
        chk("rr_ready1", req_ready, 4'b0010);
        chk("rr_flags1", flags, 8'h01);
        chk("rr_owner1", owner, 2'd0);
        tick;
        chk("rr_ready2", req_ready, 4'b0100);
        chk("rr_flags2", flags, 8'h03);
        tick;
        chk("rr_ready3", req_ready, 4'b1000);
        chk("rr_flags3", flags, 8'h07);
        tick;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("rr_flags4", flags, 8'h0F);
        chk("rr_owner4", owner, 2'd3);
        chk("rr_ready_idle", req_ready, 4'b0000);

        // 2: back-to-back toggles of flag 5 from requester 0
        drive(0, 1'b1, 2'b11, 3'd5, 1'b0);
        #1;
        chk("tgl_ready0", req_ready, 4'b0001);
        tick;
        chk("tgl_ready1", req_ready, 4'b0001);
        chk("tgl_f5_1", flags[5], 1'b1);
        tick;
        chk("tgl_ready2", req_ready, 4'b0001);
        chk("tgl_f5_2", flags[5], 1'b0);
        tick;
        drive(0, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("tgl_f5_3", flags[5], 1'b1);
        chk("tgl_flags", flags, 8'h2F);

        // 3: requester 2 locks; 1 and 3 stall until it releases
        drive(2, 1'b1, 2'b10, 3'd6, 1'b1);
        #1;
        chk("lk_ready_req2", req_ready, 4'b0100);
        tick;
        drive(2, 1'b0, 2'b00, 3'd0, 1'b0);
        drive(1, 1'b1, 2'b10, 3'd7, 1'b0);
        drive(3, 1'b1, 2'b10, 3'd7, 1'b0);
        #1;
        chk("lk_locked", locked, 1'b1);
        chk("lk_owner", owner, 2'd2);
        chk("lk_flags", flags, 8'h6F);
        chk("lk_stall0", req_ready, 4'b0000);
        for (int k = 1; k < 5; k++) begin
            tick;
            chk("lk_stall", req_ready, 4'b0000);
            chk("lk_still", locked, 1'b1);
        end
        tick;
        drive(2, 1'b1, 2'b00, 3'd0, 1'b0);
        #1;
        chk("lk_release_ready", req_ready, 4'b0100);
        tick;
        drive(2, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("lk_unlocked", locked, 1'b0);
        chk("lk_owner_after", owner, 2'd2);
        chk("lk_next_req3", req_ready, 4'b1000);
        tick;
        chk("lk_req3_flags", flags, 8'hEF);
        chk("lk_req3_owner", owner, 2'd3);
        chk("lk_next_req1", req_ready, 4'b0010);
        drive(1, 1'b0, 2'b00, 3'd0, 1'b0);
        drive(3, 1'b0, 2'b00, 3'd0, 1'b0);

        // 4: requester 1 locks then idles; forced release after 16 cycles
        drive(1, 1'b1, 2'b00, 3'd0, 1'b1);
        drive(2, 1'b1, 2'b01, 3'd0, 1'b0);
        #1;
        chk("to_ready_req1", req_ready, 4'b0010);
        tick;
        drive(1, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("to_locked", locked, 1'b1);
        chk("to_owner", owner, 2'd1);
        for (int j = 2; j <= 16; j++) begin
            tick;
            chk("to_hold_ready", req_ready, 4'b0000);
            chk("to_hold_locked", locked, 1'b1);
            chk("to_hold_pulse", lock_timeout, 1'b0);
        end
        tick;
        chk("to_pulse", lock_timeout, 1'b1);
        chk("to_unlocked", locked, 1'b0);
        chk("to_ready_req2", req_ready, 4'b0100);
        tick;
        drive(2, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("to_pulse_end", lock_timeout, 1'b0);
        chk("to_flags", flags, 8'hEE);
        chk("to_owner2", owner, 2'd2);

        // 5: clear, no-op, and out-of-range commands
        drive(0, 1'b1, 2'b01, 3'd1, 1'b0);
        #1;
        chk("op_clr_ready", req_ready, 4'b0001);
        tick;
        drive(0, 1'b1, 2'b00, 3'd2, 1'b0);
        #1;
        chk("op_clr_flags", flags, 8'hEC);
        chk("op_nop_ready", req_ready, 4'b0001);
        tick;
        drive(0, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("op_nop_flags", flags, 8'hEC);

        v6 = 2'b01; op6 = 4'b0010; idx6 = 6'd5;
        #1;
        chk("oor_ready_set", rdy6, 2'b01);
        tick;
        op6 = 4'b0011; idx6 = 6'd6;
        #1;
        chk("oor_flags_set", flags6, 6'h20);
        chk("oor_ready6", rdy6, 2'b01);
        chk("oor_owner6", owner6, 1'b0);
        tick;
        op6 = 4'b0010; idx6 = 6'd7;
        #1;
        chk("oor_flags6", flags6, 6'h20);
        chk("oor_ready7", rdy6, 2'b01);
        tick;
        v6 = 2'b00;
        #1;
        chk("oor_flags7", flags6, 6'h20);

        // 6: reset while locked with a command pending
        drive(3, 1'b1, 2'b10, 3'd0, 1'b1);
        #1;
        chk("rl_ready_req3", req_ready, 4'b1000);
        tick;
        drive(3, 1'b1, 2'b10, 3'd4, 1'b1);
        #1;
        chk("rl_locked", locked, 1'b1);
        chk("rl_flags", flags, 8'hED);
        chk("rl_ready", req_ready, 4'b1000);
        rst = 1'b1;
        tick;
        chk("rl_rst_flags", flags, 8'h00);
        chk("rl_rst_locked", locked, 1'b0);
        chk("rl_rst_owner", owner, 2'd3);
        chk("rl_rst_timeout", lock_timeout, 1'b0);
        chk("rl_rst_flags6", flags6, 6'h00);
        drive(3, 1'b0, 2'b00, 3'd0, 1'b0);
        rst = 1'b0;
        tick;
        chk("rl_post_flags", flags, 8'h00);

`ifdef SR_FLAG_ARBITER_IRQ_EN
        drive(0, 1'b1, 2'b10, 3'd4, 1'b0);
        #1;
        chk("irq_ready", req_ready, 4'b0001);
        tick;
        drive(0, 1'b0, 2'b00, 3'd0, 1'b0);
        #1;
        chk("irq_flags", flags, 8'h10);
        chk("irq_lat1", irq, 1'b0);
        tick;
        chk("irq_lat2", irq, 1'b1);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
